lsu_sram_responder: RTL and testbench

- Responder end of the core LSU data-port handshake (data_addr/data/MemR/MemW/byte_enable → line_in_d/read_valid/write_ready).
- Uncached, tagless word SRAM with programmable fixed latency.
- Used in place of data_cache in benches and uncached-region builds to isolate core LSU behaviour from cache/MSI effects.
- Also provides a backdoor preload port and read/write transaction counters.

---
 rtl/lsu_resp_pkg.sv | 12 +
 rtl/lsu_byte_merge.sv | 13 +
 rtl/lsu_sram_responder.sv | 91 +++++++++
 tb/tb_lsu_sram_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/lsu_resp_pkg.sv
// lsu_resp_pkg: shared types and constants for the LSU SRAM responder
package lsu_resp_pkg;
    localparam int LAT_W = 4;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        is_write;
        logic        err;
    } req_t;
endpackage

// File: rtl/lsu_byte_merge.sv
// lsu_byte_merge: combinational 4-lane merge of new data into an old word under byte enables
module lsu_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [3:0]  be,
    output logic [31:0] merged
);
    always_comb begin
        merged = old_word;
        for (int k = 0; k < 4; k++)
            merged[8*k +: 8] = be[k] ? new_data[8*k +: 8] : old_word[8*k +: 8];
    end
endmodule

// File: rtl/lsu_sram_responder.sv
// lsu_sram_responder: fixed-latency uncached word SRAM answering the LSU data-port handshake
module lsu_sram_responder
    import lsu_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    data_addr_i,
    input  logic [31:0]                    store_data_i,
    input  logic                           MemR_en_i,
    input  logic                           MemW_en_i,
    input  logic [3:0]                     byte_enable_i,
    output logic [31:0]                    load_data_o,
    output logic                           read_valid_o,
    output logic                           write_ready_o,
    output logic                           err_o,
    output logic                           busy_o,
    input  logic                           init_we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] init_addr_i,
    input  logic [31:0]                    init_data_i,
    output logic [31:0]                    rd_cnt_o,
    output logic [31:0]                    wr_cnt_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    logic [31:0]      mem [DEPTH_WORDS];
    state_t           state, state_n;
    logic [LAT_W-1:0] cnt, cnt_n;
    req_t             req, req_n;
    logic [31:0]      off, old_word, merged;
    logic [AW-1:0]    word;
    logic             accept, oor, unused_ok;
    assign off       = data_addr_i - BASE_ADDR;
    assign oor       = (data_addr_i < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH_WORDS));
    assign accept    = (state == IDLE) && (MemR_en_i || MemW_en_i) && !init_we_i;
    // req.addr holds the base-relative byte offset; only the word index bits address the array
    assign word      = req.addr[AW+1:2];
    assign old_word  = mem[word];
    assign unused_ok = &{1'b0, req.addr[31:AW+2], req.addr[1:0]};
    lsu_byte_merge u_merge (
        .old_word (old_word),
        .new_data (req.data),
        .be       (req.be),
        .merged   (merged)
    );
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        req_n         = req;
        read_valid_o  = (state == RESP) && !req.is_write;
        write_ready_o = (state == RESP) && req.is_write;
        err_o         = (state == RESP) && req.err;
        busy_o        = state != IDLE;
        load_data_o   = (read_valid_o && !req.err) ? old_word : 32'h0;
        case (state)
            IDLE: if (accept) begin
                req_n   = '{addr: off, data: store_data_i, be: byte_enable_i,
                            is_write: MemW_en_i, err: oor || (MemR_en_i && MemW_en_i)};
                cnt_n   = LAT_W'(LATENCY - 1);
                state_n = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_n   = cnt - 1'b1;
                state_n = (cnt_n == '0) ? RESP : WAIT;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            req      <= '0;
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            req   <= req_n;
            if (state == RESP && req.is_write) wr_cnt_o <= wr_cnt_o + 32'd1;
            if (state == RESP && !req.is_write) rd_cnt_o <= rd_cnt_o + 32'd1;
        end
    end
    // Core commit is written last so it wins over a same-word backdoor write
    always_ff @(posedge clk) begin
        if (init_we_i) mem[init_addr_i] <= init_data_i;
        if (write_ready_o && !req.err) mem[word] <= merged;
    end
endmodule

// File: tb/tb_lsu_sram_responder.sv
// tb_lsu_sram_responder: directed table-driven checks of the LSU SRAM responder
module tb_lsu_sram_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] addr, wdata, ld, rc, wc, idata;
    logic        mr, mw, rv, wr, er, bz, iwe;
    logic [3:0]  be;
    logic [11:0] iaddr;

    logic [31:0] addr1, wdata1, ld1, rc1, wc1, idata1;
    logic        mr1, mw1, rv1, wr1, er1, bz1, iwe1;
    logic [3:0]  be1;
    logic [11:0] iaddr1;

    int tests = 0;
    int fails = 0;
    int exp_rd = 0;
    int exp_wr = 0;

    lsu_sram_responder #(.LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .data_addr_i(addr), .store_data_i(wdata),
        .MemR_en_i(mr), .MemW_en_i(mw), .byte_enable_i(be),
        .load_data_o(ld), .read_valid_o(rv), .write_ready_o(wr), .err_o(er), .busy_o(bz),
        .init_we_i(iwe), .init_addr_i(iaddr), .init_data_i(idata),
        .rd_cnt_o(rc), .wr_cnt_o(wc)
    );

    lsu_sram_responder #(.LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .data_addr_i(addr1), .store_data_i(wdata1),
        .MemR_en_i(mr1), .MemW_en_i(mw1), .byte_enable_i(be1),
        .load_data_o(ld1), .read_valid_o(rv1), .write_ready_o(wr1), .err_o(er1), .busy_o(bz1),
        .init_we_i(iwe1), .init_addr_i(iaddr1), .init_data_i(idata1),
        .rd_cnt_o(rc1), .wr_cnt_o(wc1)
    );

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t v[12];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic bd(input logic [11:0] idx, input logic [31:0] d);
        iwe = 1'b1; iaddr = idx; idata = d;
        @(posedge clk); #1;
        iwe = 1'b0;
    endtask

    task automatic txn(input vec_t t);
        int seen = -1;
        mr = t.r; mw = t.w; addr = t.a; wdata = t.d; be = t.be;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rv || wr) begin
                seen = i;
                break;
            end
        end
        chk("latency", 32'(seen + 1), 32'd2);
        chk("pulse_kind", {30'b0, rv, wr}, t.w ? 32'd1 : 32'd2);
        chk("load_data", ld, t.exp_data);
        chk("err", {31'b0, er}, {31'b0, t.exp_err});
        if (t.w) exp_wr++; else exp_rd++;
        @(posedge clk); #1;
        chk("pulse_width", {30'b0, rv, wr}, 32'd0);
        chk("rd_cnt", rc, 32'(exp_rd));
        chk("wr_cnt", wc, 32'(exp_wr));
        mr = 1'b0; mw = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        logic exp_p [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        addr = '0; wdata = '0; mr = 0; mw = 0; be = '0; iwe = 0; iaddr = '0; idata = '0;
        addr1 = 32'h14; wdata1 = '0; mr1 = 0; mw1 = 0; be1 = '0; iwe1 = 0; iaddr1 = '0; idata1 = '0;
        v[0]  = '{1, 0, 32'h14,   32'h0,        4'b0000, 32'hDEADBEEF, 0};
        v[1]  = '{0, 1, 32'h0C,   32'hAABBCCDD, 4'b0101, 32'h0,        0};
        v[2]  = '{1, 0, 32'h0C,   32'h0,        4'b0000, 32'h11BB33DD, 0};
        v[3]  = '{0, 1, 32'h1C,   32'hFFFFFFFF, 4'b0000, 32'h0,        0};
        v[4]  = '{1, 0, 32'h1F,   32'h0,        4'b0000, 32'hCAFEF00D, 0};
        v[5]  = '{1, 0, 32'h4000, 32'h0,        4'b0000, 32'h0,        1};
        v[6]  = '{1, 1, 32'h4000, 32'hFFFFFFFF, 4'b1111, 32'h0,        1};
        v[7]  = '{1, 0, 32'h0,    32'h0,        4'b0000, 32'h0BADF00D, 0};
        v[8]  = '{0, 1, 32'h3FFC, 32'h12000000, 4'b1000, 32'h0,        0};
        v[9]  = '{1, 0, 32'h3FFC, 32'h0,        4'b0000, 32'h12345678, 0};
        v[10] = '{0, 1, 32'h0,    32'h0000BEEF, 4'b0011, 32'h0,        0};
        v[11] = '{1, 0, 32'h2,    32'h0,        4'b0000, 32'h0BADBEEF, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_load_data", ld, 32'h0);
        chk("rst_flags", {28'b0, rv, wr, er, bz}, 32'h0);
        chk("rst_rd_cnt", rc, 32'h0);
        chk("rst_wr_cnt", wc, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        bd(12'd5, 32'hDEADBEEF);
        bd(12'd3, 32'h11223344);
        bd(12'd7, 32'hCAFEF00D);
        bd(12'd0, 32'h0BADF00D);
        bd(12'd4095, 32'h00345678);
        for (int i = 0; i < 12; i++) txn(v[i]);

        // backdoor in the same IDLE cycle as a read pushes acceptance out by one edge
        seen = -1;
        iwe = 1'b1; iaddr = 12'd10; idata = 32'h600DCAFE;
        mr = 1'b1; mw = 1'b0; addr = 32'h28;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            iwe = 1'b0;
            if (rv) begin
                seen = i;
                break;
            end
        end
        chk("collide_latency", 32'(seen + 1), 32'd3);
        chk("collide_data", ld, 32'h600DCAFE);
        @(posedge clk); #1;
        mr = 1'b0;

        bd(12'd9, 32'h55555555);
        mw = 1'b1; addr = 32'h24; wdata = 32'hAAAAAAAA; be = 4'b1111;
        @(posedge clk); #1;
        chk("midop_busy", {31'b0, bz}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midop_rst_busy", {31'b0, bz}, 32'd0);
        chk("midop_rst_flags", {29'b0, rv, wr, er}, 32'd0);
        mw = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midop_wr_cnt", wc, 32'h0);
        chk("midop_rd_cnt", rc, 32'h0);
        exp_rd = 0; exp_wr = 0;
        txn('{1, 0, 32'h24, 32'h0, 4'b0000, 32'h55555555, 0});

        mr1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("held_pulse_%0d", i), {31'b0, rv1}, {31'b0, exp_p[i]});
            if (i == 2) mr1 = 1'b0;
        end
        chk("held_rd_cnt", rc1, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
